instr_sequencer: RTL and testbench

Fetch/decode/execute controller for the 16-bit multi-register accumulator core. It fetches 16-bit instructions from instruction memory over a req/ack handshake and holds them in the IR. It retires all-zero instructions (no-ops) without touching the execute datapath, and launches the ALU/register-file datapath for everything else. It owns the PC, the halt condition and write-back strobing; it sits between instruction memory and the existing datapath.

---
 rtl/acc_core_pkg.sv | 18 +
 rtl/ir_nop_detect.sv | 11 +
 rtl/instr_sequencer.sv | 130 +++++++++++++
 tb/tb_instr_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_core_pkg.sv
// Shared definitions for the accumulator core: sequencer state encoding,
// default address width, halt opcode and the no-op instruction word.
package acc_core_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } seq_state_e;

  localparam int unsigned PcWidth    = 16;
  localparam logic [3:0]  HaltOpcode = 4'hF;
  localparam logic [15:0] NopWord    = 16'h0000;

endpackage

// File: rtl/ir_nop_detect.sv
// Flags an instruction word as a no-op; shared with the hazard/debug logic.
module ir_nop_detect
  import acc_core_pkg::*;
(
  input  logic [15:0] ir,
  output logic        is_nop
);

  assign is_nop = (ir == NopWord);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller owning PC, IR, halt and write-back strobing.
// Optional retired-instruction counter enabled by defining SEQ_RETIRE_CNT_EN.
module instr_sequencer
  import acc_core_pkg::*;
#(
  parameter int unsigned PC_W    = PcWidth,
  parameter logic [3:0]  HALT_OP = HaltOpcode
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [15:0]     mem_rdata,
  output logic [15:0]     ir,
  output logic            exec_start,
  input  logic            exec_done,
  input  logic            exec_wb,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            reg_we,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired_cnt
);

  seq_state_e      state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;
  logic [15:0]     ir_q;
  logic            exec_start_q;
  logic            reg_we_q;
  logic            br_taken_q;
  logic [PC_W-1:0] br_target_q;
  logic            is_nop;
  logic            is_halt;

  ir_nop_detect u_nop_detect (
    .ir     (ir_q),
    .is_nop (is_nop)
  );

  assign is_halt = (ir_q[15:12] == HALT_OP);
  assign pc_inc  = pc_q + PC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      ir_q         <= NopWord;
      exec_start_q <= 1'b0;
      reg_we_q     <= 1'b0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
    end else begin
      // Strobes are single-cycle unless re-armed by a transition below.
      exec_start_q <= 1'b0;
      reg_we_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) state_q <= StFetch;
        end
        StFetch: begin
          if (mem_ack) begin
            ir_q    <= mem_rdata;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (is_nop) begin
            pc_q    <= pc_inc;
            state_q <= StFetch;
          end else if (is_halt) begin
            state_q <= StHalt;
          end else begin
            exec_start_q <= 1'b1;
            state_q      <= StExec;
          end
        end
        StExec: begin
          if (exec_done) begin
            reg_we_q    <= exec_wb;
            br_taken_q  <= branch_taken;
            br_target_q <= branch_target;
            state_q     <= StWb;
          end
        end
        StWb: begin
          pc_q    <= br_taken_q ? br_target_q : pc_inc;
          state_q <= StFetch;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_req    = (state_q == StFetch);
  assign mem_addr   = pc_q;
  assign ir         = ir_q;
  assign exec_start = exec_start_q;
  assign reg_we     = reg_we_q;
  assign busy       = (state_q != StIdle) && (state_q != StHalt);
  assign halted     = (state_q == StHalt);

`ifdef SEQ_RETIRE_CNT_EN
  logic        retire;
  logic [15:0] retired_q;

  assign retire = ((state_q == StDecode) && (is_nop || is_halt)) || (state_q == StWb);

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= 16'h0000;
    end else if (retire) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: zero-wait memory and datapath models,
// expected fetch/exec/write-back events queued by stimulus, checked by a monitor.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] ir;
  logic        exec_start;
  logic        exec_done = 1'b0;
  logic        exec_wb = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        reg_we;
  logic        busy;
  logic        halted;
  logic [15:0] retired_cnt;

  logic fast_dp = 1'b1;
  logic late_done = 1'b0;

  logic [15:0] rdata_q[$];
  logic [15:0] exp_addr[$];
  logic [15:0] exp_exec[$];
  logic [15:0] exp_we[$];

  int total = 0;
  int bad = 0;

`ifdef SEQ_RETIRE_CNT_EN
  localparam logic [15:0] CntT1 = 16'd2;
  localparam logic [15:0] CntT5 = 16'd4;
`else
  localparam logic [15:0] CntT1 = 16'd0;
  localparam logic [15:0] CntT5 = 16'd0;
`endif

  instr_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .ir            (ir),
    .exec_start    (exec_start),
    .exec_done     (exec_done),
    .exec_wb       (exec_wb),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .reg_we        (reg_we),
    .busy          (busy),
    .halted        (halted),
    .retired_cnt   (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h want no event", name, act);
  endtask

  // Memory and datapath models: drive inputs just after the active edge.
  // Datapath: opcode B is a branch to sign-extended ir[7:0], no write-back;
  // every other op writes back.
  always @(posedge clk) begin
    #1;
    if (mem_req && rdata_q.size() > 0) begin
      mem_ack   = 1'b1;
      mem_rdata = rdata_q.pop_front();
    end else begin
      mem_ack = 1'b0;
    end
    exec_done     = (fast_dp && exec_start) || late_done;
    exec_wb       = late_done ? 1'b1 : (ir[15:12] != 4'hB);
    branch_taken  = !late_done && (ir[15:12] == 4'hB);
    branch_target = {{8{ir[7]}}, ir[7:0]};
  end

  // Monitor: pops the matching expectation whenever the DUT shows an event.
  always @(negedge clk) begin
    if (mem_req && mem_ack) begin
      if (exp_addr.size() == 0) unexpected("fetch_addr", {16'h0, mem_addr});
      else check("fetch_addr", {16'h0, mem_addr}, {16'h0, exp_addr.pop_front()});
    end
    if (exec_start === 1'b1) begin
      if (exp_exec.size() == 0) unexpected("exec_start_ir", {16'h0, ir});
      else check("exec_start_ir", {16'h0, ir}, {16'h0, exp_exec.pop_front()});
    end
    if (reg_we === 1'b1) begin
      if (exp_we.size() == 0) unexpected("reg_we_ir", {16'h0, ir});
      else check("reg_we_ir", {16'h0, ir}, {16'h0, exp_we.pop_front()});
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    late_done = 1'b0;
    fast_dp = 1'b1;
    rdata_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_mem_req"}, {31'h0, mem_req}, 0);
    check({name, "_busy"}, {31'h0, busy}, 0);
    check({name, "_halted"}, {31'h0, halted}, 0);
    check({name, "_pc"}, {16'h0, mem_addr}, 0);
    check({name, "_ir"}, {16'h0, ir}, 0);
    check({name, "_strobes"}, {30'h0, exec_start, reg_we}, 0);
    check({name, "_retired"}, {16'h0, retired_cnt}, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && !halted; i++) @(negedge clk);
    check({name, "_halt_reached"}, {31'h0, halted}, 1);
  endtask

  task automatic drained(input string name);
    check({name, "_addr_left"}, exp_addr.size(), 0);
    check({name, "_exec_left"}, exp_exec.size(), 0);
    check({name, "_we_left"}, exp_we.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: no-op at 0 then halt; zero-wait memory.
    do_reset();
    check_idle("reset");
    rdata_q  = '{16'h0000, 16'hF000};
    exp_addr = '{16'h0000, 16'h0001};
    pulse_start();
    check("t1_req_after_start", {31'h0, mem_req}, 1);
    check("t1_busy", {31'h0, busy}, 1);
    @(negedge clk);
    check("t1_decode_req", {31'h0, mem_req}, 0);
    @(negedge clk);
    check("t1_refetch", {15'h0, mem_req, mem_addr}, 32'h0001_0001);
    wait_halted("t1", 10);
    check("t1_halt_busy", {31'h0, busy}, 0);
    check("t1_halt_pc", {16'h0, mem_addr}, 16'h0001);
    check("t1_halt_ir", {16'h0, ir}, 16'hF000);
    check("t1_retired", {16'h0, retired_cnt}, {16'h0, CntT1});
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("t1_stay_halted", {30'h0, halted, mem_req}, 2'b10);
      @(negedge clk);
    end
    drained("t1");

    // T2: ALU op with write-back, exec_done in first EXEC cycle.
    do_reset();
    rdata_q  = '{16'h1234, 16'hF000};
    exp_addr = '{16'h0000, 16'h0001};
    exp_exec = '{16'h1234};
    exp_we   = '{16'h1234};
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    check("t2_exec_start", {31'h0, exec_start}, 1);
    @(negedge clk);
    check("t2_wb_strobes", {30'h0, exec_start, reg_we}, 2'b01);
    @(negedge clk);
    check("t2_next_fetch", {14'h0, reg_we, mem_req, mem_addr}, 32'h0001_0001);
    wait_halted("t2", 10);
    drained("t2");

    // T3: branch at pc=5 to 0x0040.
    do_reset();
    rdata_q  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hB040, 16'hF000};
    exp_addr = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0040};
    exp_exec = '{16'hB040};
    pulse_start();
    wait_halted("t3", 40);
    check("t3_halt_pc", {16'h0, mem_addr}, 16'h0040);
    drained("t3");

    // T4: branch to 0xFFFF, no-op there wraps pc to 0.
    do_reset();
    rdata_q  = '{16'hB0FF, 16'h0000, 16'hF000};
    exp_addr = '{16'h0000, 16'hFFFF, 16'h0000};
    exp_exec = '{16'hB0FF};
    pulse_start();
    wait_halted("t4", 30);
    check("t4_halt_pc", {16'h0, mem_addr}, 16'h0000);
    drained("t4");

    // T5: three no-ops then halt.
    do_reset();
    rdata_q  = '{16'h0000, 16'h0000, 16'h0000, 16'hF000};
    exp_addr = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
    pulse_start();
    wait_halted("t5", 30);
    check("t5_halt_pc", {16'h0, mem_addr}, 16'h0003);
    check("t5_retired", {16'h0, retired_cnt}, {16'h0, CntT5});
    drained("t5");

    // T6: reset while waiting in EXEC, then a late exec_done.
    do_reset();
    fast_dp  = 1'b0;
    rdata_q  = '{16'h1234};
    exp_addr = '{16'h0000};
    exp_exec = '{16'h1234};
    pulse_start();
    repeat (4) @(negedge clk);
    check("t6_waiting", {29'h0, busy, mem_req, halted}, 3'b100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    late_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_late_done", {13'h0, reg_we, busy, halted, mem_addr}, 0);
    end
    late_done = 1'b0;
    @(negedge clk);
    check_idle("t6_after");
    drained("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
